// File: rtl/bs_trmnl_nd.sv
// bs_trmnl_nd: terminal-side bus node with a show-ahead TX FIFO popped by the
// arbiter and an ID-filtered RX FIFO filled by arbiter pushes.
// Ports: clk, reset (async active-low)
//        arbiter side: pndng/D_pop/pop, push/D_push
//        local side:   tx_wr/tx_data/tx_full, rx_rd/rx_data/rx_empty/rx_cnt
//        debug:        drop_cnt, misr_cnt (saturating at 255)
module bs_trmnl_nd #(
   parameter int          pckg_sz   = 32,
   parameter int          depth     = 8,
   parameter logic [7:0]  id        = 8'h00,
   parameter logic [7:0]  broadcast = 8'hFF
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     pndng,
   output logic [pckg_sz-1:0]       D_pop,
   input  logic                     pop,
   input  logic                     push,
   input  logic [pckg_sz-1:0]       D_push,
   input  logic                     tx_wr,
   input  logic [pckg_sz-1:0]       tx_data,
   output logic                     tx_full,
   input  logic                     rx_rd,
   output logic [pckg_sz-1:0]       rx_data,
   output logic                     rx_empty,
   output logic [$clog2(depth):0]   rx_cnt,
   output logic [7:0]               drop_cnt,
   output logic [7:0]               misr_cnt
);

   localparam int AW = $clog2(depth);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(depth);

   logic [pckg_sz-1:0] tx_mem [depth];
   logic [pckg_sz-1:0] rx_mem [depth];
   logic [AW-1:0]      tx_wp, tx_rp, rx_wp, rx_rp;
   logic [CW-1:0]      tx_cnt, rx_cnt_q;

   logic tx_pop_ok, tx_wr_ok, tx_drop;
   logic rx_hit, rx_misr, rx_rd_ok, rx_wr_ok, rx_drop, rx_full;
   logic [7:0] dst;
   logic [8:0] drop_sum;

   // Flags decode straight from the count registers
   assign pndng    = (tx_cnt != '0);
   assign tx_full  = (tx_cnt == FULL);
   assign rx_empty = (rx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == FULL);
   assign rx_cnt   = rx_cnt_q;

   // Storage is unreset, so heads are masked to zero while empty
   assign D_pop   = pndng    ? tx_mem[tx_rp] : '0;
   assign rx_data = rx_empty ? '0 : rx_mem[rx_rp];

   assign dst = D_push[pckg_sz-1 -: 8];

   // A pop on a full FIFO frees the slot the same cycle, so the write lands
   assign tx_pop_ok = pop && pndng;
   assign tx_wr_ok  = tx_wr && (!tx_full || pop);
   assign tx_drop   = tx_wr && tx_full && !pop;

   assign rx_hit   = push && ((dst == id) || (dst == broadcast));
   assign rx_misr  = push && !rx_hit;
   assign rx_rd_ok = rx_rd && !rx_empty;
   assign rx_wr_ok = rx_hit && (!rx_full || rx_rd);
   assign rx_drop  = rx_hit && rx_full && !rx_rd;

   assign drop_sum = {1'b0, drop_cnt} + 9'(tx_drop) + 9'(rx_drop);

   always_ff @(posedge clk) begin
      if (tx_wr_ok) tx_mem[tx_wp] <= tx_data;
      if (rx_wr_ok) rx_mem[rx_wp] <= D_push;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_wp    <= '0;
         tx_rp    <= '0;
         tx_cnt   <= '0;
         rx_wp    <= '0;
         rx_rp    <= '0;
         rx_cnt_q <= '0;
         drop_cnt <= '0;
         misr_cnt <= '0;
      end else begin
         if (tx_wr_ok)  tx_wp <= tx_wp + AW'(1);
         if (tx_pop_ok) tx_rp <= tx_rp + AW'(1);
         case ({tx_wr_ok, tx_pop_ok})
            2'b10:   tx_cnt <= tx_cnt + CW'(1);
            2'b01:   tx_cnt <= tx_cnt - CW'(1);
            default: tx_cnt <= tx_cnt;
         endcase

         if (rx_wr_ok) rx_wp <= rx_wp + AW'(1);
         if (rx_rd_ok) rx_rp <= rx_rp + AW'(1);
         case ({rx_wr_ok, rx_rd_ok})
            2'b10:   rx_cnt_q <= rx_cnt_q + CW'(1);
            2'b01:   rx_cnt_q <= rx_cnt_q - CW'(1);
            default: rx_cnt_q <= rx_cnt_q;
         endcase

         drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
         if (rx_misr && (misr_cnt != 8'hFF))
            misr_cnt <= misr_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_bs_trmnl_nd.sv
// tb_bs_trmnl_nd: randomized + directed bench for bs_trmnl_nd,
// checked against a queue-based reference model.
module tb_bs_trmnl_nd;

   localparam int         W     = 32;
   localparam int         DEPTH = 8;
   localparam logic [7:0] ID    = 8'h03;
   localparam logic [7:0] BC    = 8'hFF;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pndng, pop, push, tx_wr, tx_full, rx_rd, rx_empty;
   logic [W-1:0]  D_pop, D_push, tx_data, rx_data;
   logic [3:0]    rx_cnt;
   logic [7:0]    drop_cnt, misr_cnt;

   always #5 clk = ~clk;

   bs_trmnl_nd #(.pckg_sz(W), .depth(DEPTH), .id(ID), .broadcast(BC)) dut (
      .clk(clk), .reset(rst_n),
      .pndng(pndng), .D_pop(D_pop), .pop(pop),
      .push(push), .D_push(D_push),
      .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
      .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty),
      .rx_cnt(rx_cnt), .drop_cnt(drop_cnt), .misr_cnt(misr_cnt)
   );

   // reference model
   logic [W-1:0] tx_q[$];
   logic [W-1:0] rx_q[$];
   int m_drop, m_misr;
   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [W-1:0] got,
                      input logic [W-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   task automatic chk_all();
      chk("pndng",    W'(pndng),    W'(tx_q.size() != 0));
      chk("D_pop",    D_pop,        tx_q.size() != 0 ? tx_q[0] : '0);
      chk("tx_full",  W'(tx_full),  W'(tx_q.size() == DEPTH));
      chk("rx_empty", W'(rx_empty), W'(rx_q.size() == 0));
      chk("rx_data",  rx_data,      rx_q.size() != 0 ? rx_q[0] : '0);
      chk("rx_cnt",   W'(rx_cnt),   W'(rx_q.size()));
      chk("drop_cnt", W'(drop_cnt), W'(m_drop));
      chk("misr_cnt", W'(misr_cnt), W'(m_misr));
   endtask

   task automatic model_clear();
      tx_q.delete();
      rx_q.delete();
      m_drop = 0;
      m_misr = 0;
   endtask

   // Called at a falling edge: drive inputs, advance model by one rising
   // edge, then check at the next falling edge.
   task automatic cyc(input logic i_tx_wr, input logic [W-1:0] i_tx_data,
                      input logic i_pop, input logic i_push,
                      input logic [W-1:0] i_dpush, input logic i_rx_rd);
      bit t_pop, t_ok, r_pop, r_hit, r_ok;
      int drops;
      tx_wr = i_tx_wr; tx_data = i_tx_data; pop = i_pop;
      push = i_push; D_push = i_dpush; rx_rd = i_rx_rd;

      drops = 0;
      t_pop = i_pop && tx_q.size() > 0;
      t_ok  = i_tx_wr && (tx_q.size() < DEPTH || t_pop);
      if (i_tx_wr && !t_ok) drops++;
      if (t_pop) void'(tx_q.pop_front());
      if (t_ok) tx_q.push_back(i_tx_data);

      r_hit = i_push && (i_dpush[31:24] == ID || i_dpush[31:24] == BC);
      if (i_push && !r_hit && m_misr < 255) m_misr++;
      r_pop = i_rx_rd && rx_q.size() > 0;
      r_ok  = r_hit && (rx_q.size() < DEPTH || r_pop);
      if (r_hit && !r_ok) drops++;
      if (r_pop) void'(rx_q.pop_front());
      if (r_ok) rx_q.push_back(i_dpush);

      m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;

      @(negedge clk);
      chk_all();
   endtask

   function automatic logic [W-1:0] rnd_pkt();
      logic [7:0] d;
      case ($urandom_range(0, 3))
         0, 1:    d = ID;
         2:       d = BC;
         default: d = 8'($urandom);
      endcase
      return {d, 24'($urandom)};
   endfunction

   task automatic idle();
      cyc(0, '0, 0, 0, '0, 0);
   endtask

   initial begin
      rst_n = 0;
      tx_wr = 0; tx_data = '0; pop = 0; push = 0; D_push = '0; rx_rd = 0;
      model_clear();
      #12;
      chk_all();
      @(negedge clk);
      rst_n = 1;
      chk_all();

      // TX: three writes then three pops
      for (int i = 0; i < 3; i++) cyc(1, 32'h1000_0000 + W'(i), 0, 0, '0, 0);
      for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, '0, 0);
      cyc(0, '0, 1, 0, '0, 0);

      // RX filtering
      cyc(0, '0, 0, 1, 32'h03AA_0001, 0);
      cyc(0, '0, 0, 1, 32'hFFBB_0002, 0);
      cyc(0, '0, 0, 1, 32'h05CC_0003, 0);
      chk("plan_rx_cnt2", W'(rx_cnt), 32'd2);
      chk("plan_misr1",   W'(misr_cnt), 32'd1);

      // RX overflow
      for (int i = 0; i < 6; i++) cyc(0, '0, 0, 1, 32'h0300_0100 + W'(i), 0);
      for (int i = 0; i < 2; i++) cyc(0, '0, 0, 1, 32'hFF00_0200 + W'(i), 0);
      chk("plan_drop2", W'(drop_cnt), 32'd2);
      cyc(0, '0, 0, 1, 32'h0300_0300, 1);
      chk("plan_rx_full_rd", W'(rx_cnt), 32'd8);
      for (int i = 0; i < 9; i++) cyc(0, '0, 0, 0, '0, 1);

      // TX full with simultaneous write+pop across the wrap
      for (int i = 0; i < DEPTH; i++) cyc(1, 32'h2000_0000 + W'(i), 0, 0, '0, 0);
      cyc(1, 32'hDEAD_0000, 0, 0, '0, 0);
      for (int i = 0; i < 10; i++) cyc(1, 32'h3000_0000 + W'(i), 1, 0, '0, 0);
      for (int i = 0; i < DEPTH + 1; i++) cyc(0, '0, 1, 0, '0, 0);

      // misroute saturation
      for (int i = 0; i < 300; i++) cyc(0, '0, 0, 1, 32'h0500_0000 + W'(i), 0);
      chk("plan_misr_sat", W'(misr_cnt), 32'd255);

      // async reset mid-cycle with 4 entries in each FIFO
      for (int i = 0; i < 4; i++)
         cyc(1, 32'h4000_0000 + W'(i), 0, 1, 32'h0300_4000 + W'(i), 0);
      #2 rst_n = 0;
      #1;
      model_clear();
      chk("rst_pndng",  W'(pndng), 32'd0);
      chk("rst_rx_emp", W'(rx_empty), 32'd1);
      chk_all();
      @(negedge clk);
      rst_n = 1;
      cyc(1, 32'h5000_0001, 0, 0, '0, 0);
      chk("post_rst_pndng", W'(pndng), 32'd1);
      cyc(0, '0, 1, 0, '0, 0);

      // randomized traffic, with bursts that push drops to saturation
      for (int i = 0; i < 3000; i++) begin
         logic w, p, ps, r;
         w  = ($urandom_range(0, 99) < 60);
         p  = ($urandom_range(0, 99) < (i < 1500 ? 40 : 5));
         ps = ($urandom_range(0, 99) < 60);
         r  = ($urandom_range(0, 99) < (i < 1500 ? 40 : 5));
         cyc(w, W'($urandom), p, ps, rnd_pkt(), r);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/bs_trmnl_nd.md
# bs_trmnl_nd

Terminal-side node for the bus generator/arbiter: one instance sits at each of the `drvrs` terminals and speaks the other end of the arbiter's `pndng`/`pop`/`D_pop` and `push`/`D_push` handshake. It buffers locally generated packets in a show-ahead TX FIFO that the arbiter pops. It also filters packets the arbiter pushes by destination ID (own ID or broadcast) and queues them in an RX FIFO for the local consumer. Dropped and misrouted traffic is counted for debug and coverage.

## Interface
- `pckg_sz`, 32, packet width in bits; the destination ID is `[pckg_sz-1 -: 8]`.
- `depth`, 8, entries per FIFO; power of two, at least 2.
- `id`, 0, 8-bit terminal ID of this node.
- `broadcast`, 8'hFF, destination ID accepted by every node.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `pndng`  out  1  TX FIFO non-empty; presented to the arbiter.
- `D_pop`  out  pckg_sz  TX FIFO head; valid while `pndng`=1, all zeros otherwise.
- `pop`  in  1  arbiter consumes the TX head this cycle.
- `push`  in  1  arbiter delivers `D_push` this cycle.
- `D_push`  in  pckg_sz  delivered packet.
- `tx_wr`  in  1  local write request into the TX FIFO.
- `tx_data`  in  pckg_sz  local packet to send.
- `tx_full`  out  1  TX FIFO holds `depth` entries.
- `rx_rd`  in  1  local read of the RX head.
- `rx_data`  out  pckg_sz  RX FIFO head; valid while `rx_empty`=0, zeros otherwise.
- `rx_empty`  out  1  RX FIFO empty.
- `rx_cnt`  out  $clog2(depth)+1  RX occupancy.
- `drop_cnt`  out  8  packets lost to RX overflow or TX-full writes; saturates at 255.
- `misr_cnt`  out  8  pushes whose destination ID is neither `id` nor `broadcast`; saturates at 255.

## Operation
- Reset values:
  - `pndng`=0, `D_pop`=0, `tx_full`=0.
  - `rx_empty`=1, `rx_data`=0, `rx_cnt`=0.
  - `drop_cnt`=0, `misr_cnt`=0.
  - All FIFO pointers and counts are 0.
  - FIFO storage is not reset; the zero-forcing on `D_pop` and `rx_data` hides it.
- Each FIFO is a circular buffer with read/write pointers of $clog2(depth) bits that wrap modulo `depth`, plus a count register.
- TX write:
  - `tx_wr`=1 with `tx_full`=0 stores `tx_data`.
  - `tx_wr`=1 with `tx_full`=1 drops the packet and increments `drop_cnt`.
  - Exception: when the TX FIFO is full and `pop`=1 in the same cycle, the write succeeds and the count is unchanged.
- TX pop:
  - `pop`=1 with `pndng`=1 advances the read pointer.
  - `pop`=1 with `pndng`=0 is ignored: no state change, no counter change.
  - `tx_wr`+`pop` on an empty FIFO: the write happens and the pop is ignored.
- RX accept: `push`=1 is accepted when `D_push[pckg_sz-1 -: 8]` equals `id` or `broadcast`. Otherwise the packet is discarded and `misr_cnt` increments.
- RX write:
  - An accepted push with `rx_cnt`<`depth` is stored.
  - An accepted push with the RX FIFO full and `rx_rd`=0 is dropped and increments `drop_cnt`.
  - An accepted push with the RX FIFO full and `rx_rd`=1 succeeds; the count is unchanged.
- RX read:
  - `rx_rd`=1 with `rx_empty`=0 advances the head.
  - `rx_rd`=1 while empty is ignored.
  - Push and read on an empty RX FIFO: the store happens and the read is ignored.
- Counters:
  - Both counters saturate at 255.
  - A TX drop and an RX drop in the same cycle add 2 to `drop_cnt`, saturating.
- The packet payload is never modified; the ID field is stored as received.

## Timing
- All flag and count outputs are registered state or decoded directly from it; no combinational path from `pop`, `push`, `tx_wr` or `rx_rd` to any output.
- TX latency:
  - A write at edge t is visible as `pndng`=1 with `D_pop` at the head from t+1 if the FIFO was empty.
  - After a pop at edge t, the next head appears in cycle t+1.
- RX latency: a push accepted at edge t gives `rx_empty`=0 and `rx_data` valid in cycle t+1; `rx_cnt` updates at the same edge.
- Back-to-back operation: `pop` may stay high on consecutive cycles and drains one entry per cycle. Likewise `push` and `rx_rd`.
- Reset asserted mid-transfer: outputs go to their reset values asynchronously, in-flight packets are lost, and counters clear. After deassertion, the first edge is a normal operating edge.

## Test plan
- Reset, then write 3 packets via `tx_wr`, then `pop` for 3 cycles → `pndng` rises the cycle after the first write; `D_pop` shows the packets in FIFO order; `pndng`=0 after the third pop.
- With `id`=8'h03, push 32'h03AA_0001, 32'hFFBB_0002 and 32'h05CC_0003 → RX holds the first two, `rx_cnt`=2, `misr_cnt`=1.
- Fill the RX FIFO to `depth`=8, then push 2 matching packets with `rx_rd`=0 → `drop_cnt`=2, `rx_cnt`=8. Then push with `rx_rd`=1 → accepted, `rx_cnt` stays 8, `drop_cnt` stays 2.
- Fill the TX FIFO, then assert `tx_wr`+`pop` together for 10 cycles → no drops; pointers wrap; `D_pop` order is preserved across the wrap.
- Push 300 misrouted packets → `misr_cnt` saturates at 255.
- With 4 entries in each FIFO, assert `reset`=0 between clock edges → `pndng`=0, `rx_empty`=1 and both counters 0 immediately. After release, a single `tx_wr` yields `pndng`=1 one cycle later.
